v_issue_ctrl: RTL and testbench
===============================

Name: v_issue_ctrl

Overview:
- Scalar-side issue controller for the vector unit; it is the initiator end of the vector instruction interface.
- Accepts decoded vector instructions from the scalar pipeline over a valid/ready handshake and buffers them in a small FIFO.
- Drives the vector unit's I_* fields with a one-cycle I_start pulse and assigns rotating instruction IDs.
- Honours the vector unit's stall, tracks outstanding instructions via DONE, enforces memory ordering, and performs flushes with I_clear.

Parameters:
- FIFO_DEPTH, 4, instruction buffer entries (power of 2, at least 2).
- MAX_OUT, 8, maximum number of issued-but-not-DONE instructions (at most 8, so IDs stay unique).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  scalar pipeline flush request (level).
- in_valid  in  1  scalar pipeline has an instruction.
- in_ready  out  1  the block accepts the instruction this cycle.
- in_instr  in  99  packed fields, MSB to LSB: vs1[5], vs2[5], vd[5], RS1[32], RS2[32], uimm5[5], funct[4], permute[2], mask_en[1], ALUSrc[2], dmr[1], dmw[1], reg_we[1], mem_reg[1], mode_lsu[2].
- I_start  out  1  one-cycle issue strobe.
- I_id  out  3  ID of the instruction being issued.
- I_clear  out  1  one-cycle clear-all strobe.
- I_vs1, I_vs2, I_vd, I_uimm5  out  5 each  unpacked instruction fields.
- I_RS1, I_RS2  out  32 each  unpacked instruction fields.
- I_funct  out  4  unpacked instruction field.
- I_permute, I_ALUSrc, I_mode_lsu  out  2 each  unpacked instruction fields.
- I_mask_en, I_dmr, I_dmw, I_reg_we, I_mem_reg  out  1 each  unpacked instruction fields.
- stall  in  1  vector unit cannot accept a new instruction.
- DONE  in  1  one-cycle pulse; exactly one instruction has retired, in issue order.
- outstanding  out  4  count of issued-but-not-DONE instructions.
- busy  out  1  FIFO non-empty, or outstanding != 0, or state != IDLE.
- err_underflow  out  1  sticky flag: DONE arrived while outstanding == 0.

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs go to 0; FIFO empty; ID counter 0; state IDLE.
  - in_ready is 0 while reset is asserted and 1 in the first cycle after release.
- All I_* outputs are registered. Field outputs update only on an issue and hold otherwise.
- in_ready = !fifo_full && !flush && state != CLEAR. A push happens when in_valid && in_ready.
- Issue condition, evaluated in cycle t:
  - FIFO non-empty;
  - state ISSUE;
  - stall == 0;
  - outstanding < MAX_OUT;
  - I_start == 0 in cycle t;
  - flush == 0.
  - When all hold: pop the FIFO head, register its fields, set I_start = 1 and I_id = id_cnt at t+1, and increment id_cnt mod 8.
- Consecutive I_start pulses are separated by at least one idle cycle, which gives the vector unit one cycle to raise stall.
- Latency: a push into an empty FIFO in IDLE at cycle t produces I_start at t+2.
- FSM states:
  - IDLE: FIFO empty. Go to ISSUE when the FIFO becomes non-empty.
  - ISSUE: issue per the rule above.
    - If the head has dmr or dmw set and outstanding != 0, go to MEM_WAIT with no issue.
    - Go to IDLE when the FIFO is empty after a pop.
  - MEM_WAIT: hold the head. When outstanding == 0 (including a DONE that clears it this cycle), return to ISSUE; the memory op then issues under the normal rule.
  - CLEAR: entered from any state when flush == 1.
    - I_clear = 1 for exactly one cycle.
    - FIFO emptied, outstanding = 0, id_cnt = 0, I_start forced to 0.
    - Next state IDLE.
    - If flush is still high, remain in CLEAR with I_clear low after the first cycle; I_clear re-pulses only on a new rising edge of flush.
- Outstanding counter:
  - +1 on an issue, -1 on DONE; both in the same cycle leaves it unchanged.
  - DONE with outstanding == 0: counter stays 0 and err_underflow sets. Only reset clears err_underflow; flush does not.
- Simultaneous push and pop on a full FIFO: the pop frees the slot, but in_ready already read 0 that cycle, so no push occurs. No combinational path from pop to in_ready.
- Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- Flush wins over a push and over an issue in the same cycle.
- Reset asserted mid-operation aborts everything immediately; I_clear is not pulsed.

Test Plan:
- Single ALU instruction (vs1=1, vs2=2, vd=3, funct=4'h2) pushed at cycle 0 → I_start=1 at cycle 2 with I_id=0 and I_vd=3, outstanding=1; DONE at cycle 5 → outstanding=0, busy=0 at cycle 6.
- Push 4 instructions back-to-back with FIFO_DEPTH=4 and DONE held low → in_ready=0 once 4 are held; I_start at cycles 2, 4, 6, 8 with I_id 0, 1, 2, 3; outstanding reaches 4.
- stall=1 for cycles 3–9 with 2 instructions queued → exactly one I_start before cycle 4; the second I_start comes one cycle after stall falls; fields held stable meanwhile.
- ALU op issued (outstanding=1), then a load (dmr=1) queued → state MEM_WAIT, no I_start; DONE pulse → load issues 2 cycles later with I_dmr=1.
- 9 ALU ops with DONE held low → 8 issues (I_id 0..7, outstanding=8); the 9th holds until the first DONE, then issues with I_id=0.
- flush with 3 queued and 2 outstanding → I_clear for 1 cycle, outstanding=0, FIFO empty; next issue has I_id=0. Then DONE at outstanding=0 → err_underflow=1.

Source files
------------

// File: rtl/v_issue_ctrl.sv
// Scalar-side vector issue controller: buffers decoded vector instructions,
// issues them with rotating IDs, tracks outstanding work and handles flushes.
module v_issue_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUT    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [98:0] in_instr,
    output logic        I_start,
    output logic [2:0]  I_id,
    output logic        I_clear,
    output logic [4:0]  I_vs1,
    output logic [4:0]  I_vs2,
    output logic [4:0]  I_vd,
    output logic [4:0]  I_uimm5,
    output logic [31:0] I_RS1,
    output logic [31:0] I_RS2,
    output logic [3:0]  I_funct,
    output logic [1:0]  I_permute,
    output logic [1:0]  I_ALUSrc,
    output logic [1:0]  I_mode_lsu,
    output logic        I_mask_en,
    output logic        I_dmr,
    output logic        I_dmw,
    output logic        I_reg_we,
    output logic        I_mem_reg,
    input  logic        stall,
    input  logic        DONE,
    output logic [3:0]  outstanding,
    output logic        busy,
    output logic        err_underflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        MEM_WAIT = 2'd2,
        CLEAR    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [98:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2:0]         id_cnt_q, id_cnt_d;
    logic [3:0]         out_cnt_q, out_cnt_d;
    logic               start_q, start_d;
    logic               clear_q, clear_d;
    logic [2:0]         id_q, id_d;
    logic [98:0]        instr_q, instr_d;
    logic               err_q, err_d;
    logic               flush_q;

    logic        fifo_full;
    logic        push;
    logic        issue;
    logic        retire;
    logic [98:0] head;
    logic        head_mem;

    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    // Registered state only: a pop this cycle never reopens in_ready this cycle.
    assign in_ready  = reset && !fifo_full && !flush && (state_q != CLEAR);
    assign push      = in_valid && in_ready;
    assign head      = mem_q[rd_ptr_q];
    assign head_mem  = (count_q != '0) && (head[5] || head[4]);
    assign retire    = DONE && (out_cnt_q != 4'd0);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        id_cnt_d = id_cnt_q;
        out_cnt_d = out_cnt_q;
        id_d     = id_q;
        instr_d  = instr_q;
        err_d    = err_q || (DONE && (out_cnt_q == 4'd0));
        clear_d  = flush && !flush_q;

        unique case (state_q)
            IDLE: begin
                if (push || (count_q != '0)) state_d = ISSUE;
            end
            ISSUE: begin
                if (head_mem && (out_cnt_q != 4'd0)) begin
                    state_d = MEM_WAIT;
                end else if ((count_q != '0) && !stall && !start_q &&
                             (out_cnt_q < 4'(MAX_OUT))) begin
                    issue = 1'b1;
                    if ((count_q == CNT_W'(1)) && !push) state_d = IDLE;
                end else if ((count_q == '0) && !push) begin
                    state_d = IDLE;
                end
            end
            MEM_WAIT: begin
                if ((out_cnt_q == 4'd0) || ((out_cnt_q == 4'd1) && DONE)) state_d = ISSUE;
            end
            CLEAR: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            id_d     = id_cnt_q;
            id_cnt_d = id_cnt_q + 3'd1;
            instr_d  = head;
        end
        if (push && !issue) count_d = count_q + CNT_W'(1);
        else if (!push && issue) count_d = count_q - CNT_W'(1);

        if (issue && !retire) out_cnt_d = out_cnt_q + 4'd1;
        else if (!issue && retire) out_cnt_d = out_cnt_q - 4'd1;

        // Flush overrides everything above, including a same-cycle push or issue.
        if (flush) begin
            state_d   = CLEAR;
            issue     = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            id_cnt_d  = 3'd0;
            out_cnt_d = 4'd0;
            id_d      = id_q;
            instr_d   = instr_q;
        end
        start_d = issue;
    end

    // NOTE: the buffer storage has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_instr;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            id_cnt_q  <= 3'd0;
            out_cnt_q <= 4'd0;
            start_q   <= 1'b0;
            clear_q   <= 1'b0;
            id_q      <= 3'd0;
            instr_q   <= '0;
            err_q     <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            id_cnt_q  <= id_cnt_d;
            out_cnt_q <= out_cnt_d;
            start_q   <= start_d;
            clear_q   <= clear_d;
            id_q      <= id_d;
            instr_q   <= instr_d;
            err_q     <= err_d;
            flush_q   <= flush;
        end
    end

    assign I_start       = start_q;
    assign I_clear       = clear_q;
    assign I_id          = id_q;
    assign I_vs1         = instr_q[98:94];
    assign I_vs2         = instr_q[93:89];
    assign I_vd          = instr_q[88:84];
    assign I_RS1         = instr_q[83:52];
    assign I_RS2         = instr_q[51:20];
    assign I_uimm5       = instr_q[19:15];
    assign I_funct       = instr_q[14:11];
    assign I_permute     = instr_q[10:9];
    assign I_mask_en     = instr_q[8];
    assign I_ALUSrc      = instr_q[7:6];
    assign I_dmr         = instr_q[5];
    assign I_dmw         = instr_q[4];
    assign I_reg_we      = instr_q[3];
    assign I_mem_reg     = instr_q[2];
    assign I_mode_lsu    = instr_q[1:0];
    assign outstanding   = out_cnt_q;
    assign busy          = (count_q != '0) || (out_cnt_q != 4'd0) || (state_q != IDLE);
    assign err_underflow = err_q;

endmodule

// File: tb/tb_v_issue_ctrl.sv
// Directed bench for v_issue_ctrl: issue latency, stall, memory ordering,
// outstanding limit with ID wrap, flush and underflow, mid-operation reset.
module tb_v_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [98:0] in_instr;
    logic        I_start;
    logic [2:0]  I_id;
    logic        I_clear;
    logic [4:0]  I_vs1, I_vs2, I_vd, I_uimm5;
    logic [31:0] I_RS1, I_RS2;
    logic [3:0]  I_funct;
    logic [1:0]  I_permute, I_ALUSrc, I_mode_lsu;
    logic        I_mask_en, I_dmr, I_dmw, I_reg_we, I_mem_reg;
    logic        stall;
    logic        DONE;
    logic [3:0]  outstanding;
    logic        busy;
    logic        err_underflow;

    int checks = 0;
    int errors = 0;

    v_issue_ctrl #(.FIFO_DEPTH(4), .MAX_OUT(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .I_start(I_start), .I_id(I_id), .I_clear(I_clear),
        .I_vs1(I_vs1), .I_vs2(I_vs2), .I_vd(I_vd), .I_uimm5(I_uimm5),
        .I_RS1(I_RS1), .I_RS2(I_RS2), .I_funct(I_funct),
        .I_permute(I_permute), .I_ALUSrc(I_ALUSrc), .I_mode_lsu(I_mode_lsu),
        .I_mask_en(I_mask_en), .I_dmr(I_dmr), .I_dmw(I_dmw),
        .I_reg_we(I_reg_we), .I_mem_reg(I_mem_reg),
        .stall(stall), .DONE(DONE), .outstanding(outstanding),
        .busy(busy), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [98:0] mk_instr(input logic [4:0] vs1, input logic [4:0] vs2,
                                             input logic [4:0] vd, input logic [3:0] funct,
                                             input logic dmr, input logic [31:0] rs1);
        return {vs1, vs2, vd, rs1, 32'h0, 5'd0, funct, 2'b00, 1'b0, 2'b00,
                dmr, 1'b0, 1'b0, 1'b0, 2'b00};
    endfunction

    logic [2:0] ids [16];
    logic [4:0] vds [16];
    int         pushes;
    int         n_iss;
    logic       acc;

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
        stall = 1'b0; DONE = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_I_start", 32'(I_start), 0);
        check("rst_outstanding", 32'(outstanding), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_I_clear", 32'(I_clear), 0);
        check("rst_err", 32'(err_underflow), 0);
        reset = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 1);

        // Single ALU instruction: I_start two edges after the push
        tick();
        in_valid = 1'b1;
        in_instr = mk_instr(5'd1, 5'd2, 5'd3, 4'h2, 1'b0, 32'h1234);
        tick();
        in_valid = 1'b0;
        check("t1_no_start_yet", 32'(I_start), 0);
        check("t1_busy", 32'(busy), 1);
        tick();
        check("t1_start", 32'(I_start), 1);
        check("t1_id", 32'(I_id), 0);
        check("t1_vd", 32'(I_vd), 3);
        check("t1_vs1", 32'(I_vs1), 1);
        check("t1_vs2", 32'(I_vs2), 2);
        check("t1_funct", 32'(I_funct), 2);
        check("t1_rs1", I_RS1, 32'h1234);
        check("t1_outstanding", 32'(outstanding), 1);
        tick();
        check("t1_start_pulse", 32'(I_start), 0);
        check("t1_vd_hold", 32'(I_vd), 3);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        check("t1_out_done", 32'(outstanding), 0);
        check("t1_idle", 32'(busy), 0);

        // Fill the FIFO under stall, then stall again between issues
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_instr = mk_instr(5'd0, 5'd0, 5'(10 + i), 4'h1, 1'b0, 32'h0);
            tick();
        end
        in_valid = 1'b0;
        check("t2_full", 32'(in_ready), 0);
        check("t2_stalled", 32'(I_start), 0);
        stall = 1'b0;
        tick();
        check("t2_start0", 32'(I_start), 1);
        check("t2_id0", 32'(I_id), 1);
        check("t2_vd0", 32'(I_vd), 10);
        check("t2_ready_after_pop", 32'(in_ready), 1);
        tick();
        check("t2_gap", 32'(I_start), 0);
        tick();
        check("t2_start1", 32'(I_start), 1);
        check("t2_id1", 32'(I_id), 2);
        check("t2_vd1", 32'(I_vd), 11);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_stall_nostart", 32'(I_start), 0);
            check("t2_stall_hold_vd", 32'(I_vd), 11);
        end
        stall = 1'b0;
        tick();
        check("t2_start2", 32'(I_start), 1);
        check("t2_id2", 32'(I_id), 3);
        check("t2_vd2", 32'(I_vd), 12);
        tick();
        tick();
        check("t2_start3", 32'(I_start), 1);
        check("t2_id3", 32'(I_id), 4);
        check("t2_vd3", 32'(I_vd), 13);
        check("t2_outstanding4", 32'(outstanding), 4);
        DONE = 1'b1;
        repeat (4) tick();
        DONE = 1'b0;
        check("t2_drained", 32'(outstanding), 0);
        check("t2_idle", 32'(busy), 0);

        // Memory ordering: load waits until the ALU op retires
        in_valid = 1'b1;
        in_instr = mk_instr(5'd0, 5'd0, 5'd5, 4'h3, 1'b0, 32'h0);
        tick();
        in_instr = mk_instr(5'd0, 5'd0, 5'd6, 4'h0, 1'b1, 32'h0);
        tick();
        in_valid = 1'b0;
        check("t3_alu_start", 32'(I_start), 1);
        check("t3_alu_id", 32'(I_id), 5);
        check("t3_alu_vd", 32'(I_vd), 5);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_wait_nostart", 32'(I_start), 0);
        end
        check("t3_wait_vd", 32'(I_vd), 5);
        check("t3_wait_out", 32'(outstanding), 1);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        check("t3_done_nostart", 32'(I_start), 0);
        check("t3_done_out", 32'(outstanding), 0);
        tick();
        check("t3_ld_start", 32'(I_start), 1);
        check("t3_ld_dmr", 32'(I_dmr), 1);
        check("t3_ld_vd", 32'(I_vd), 6);
        check("t3_ld_id", 32'(I_id), 6);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        check("t3_out0", 32'(outstanding), 0);

        // Outstanding limit: nine ops, eight issue, IDs continue from 7 and wrap
        pushes = 0;
        n_iss = 0;
        for (int c = 0; c < 40; c++) begin
            in_valid = (pushes < 9);
            in_instr = mk_instr(5'd1, 5'd2, 5'(16 + pushes), 4'h1, 1'b0, 32'(c));
            acc = in_valid && in_ready;
            tick();
            if (acc) pushes++;
            if (I_start) begin
                if (n_iss < 16) begin
                    ids[n_iss] = I_id;
                    vds[n_iss] = I_vd;
                end
                n_iss++;
            end
        end
        in_valid = 1'b0;
        check("t4_pushes", 32'(pushes), 9);
        check("t4_issues", 32'(n_iss), 8);
        check("t4_out8", 32'(outstanding), 8);
        check("t4_busy", 32'(busy), 1);
        for (int k = 0; k < 8; k++) begin
            check("t4_id", 32'(ids[k]), 32'((7 + k) % 8));
            check("t4_vd", 32'(vds[k]), 32'(16 + k));
        end
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        check("t4_done_nostart", 32'(I_start), 0);
        check("t4_out7", 32'(outstanding), 7);
        tick();
        check("t4_ninth_start", 32'(I_start), 1);
        check("t4_ninth_id", 32'(I_id), 7);
        check("t4_ninth_vd", 32'(I_vd), 24);
        check("t4_ninth_out", 32'(outstanding), 8);

        // Flush with queued and outstanding work
        DONE = 1'b1;
        repeat (6) tick();
        DONE = 1'b0;
        check("t5_out2", 32'(outstanding), 2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_instr = mk_instr(5'd0, 5'd0, 5'(30 + i), 4'h1, 1'b0, 32'h0);
            tick();
        end
        in_valid = 1'b0;
        flush = 1'b1;
        #1;
        check("t5_flush_ready", 32'(in_ready), 0);
        tick();
        check("t5_clear", 32'(I_clear), 1);
        check("t5_out_cleared", 32'(outstanding), 0);
        check("t5_no_start", 32'(I_start), 0);
        tick();
        check("t5_clear_once", 32'(I_clear), 0);
        check("t5_busy_clear", 32'(busy), 1);
        flush = 1'b0;
        #1;
        check("t5_ready_in_clear", 32'(in_ready), 0);
        tick();
        check("t5_idle", 32'(busy), 0);
        check("t5_ready_idle", 32'(in_ready), 1);
        stall = 1'b0;
        in_valid = 1'b1;
        in_instr = mk_instr(5'd0, 5'd0, 5'd7, 4'h1, 1'b0, 32'h0);
        tick();
        in_valid = 1'b0;
        tick();
        check("t5_post_start", 32'(I_start), 1);
        check("t5_post_id", 32'(I_id), 0);
        check("t5_post_vd", 32'(I_vd), 7);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        check("t5_out0", 32'(outstanding), 0);
        check("t5_no_err", 32'(err_underflow), 0);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        check("t5_err", 32'(err_underflow), 1);
        check("t5_err_out", 32'(outstanding), 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_reclear", 32'(I_clear), 1);
        check("t5_err_sticky", 32'(err_underflow), 1);
        tick();

        // Reset mid-operation
        in_valid = 1'b1;
        in_instr = mk_instr(5'd9, 5'd9, 5'd9, 4'h1, 1'b0, 32'h0);
        tick();
        in_valid = 1'b0;
        tick();
        check("t6_start", 32'(I_start), 1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_start", 32'(I_start), 0);
        check("t6_rst_vd", 32'(I_vd), 0);
        check("t6_rst_out", 32'(outstanding), 0);
        check("t6_rst_err", 32'(err_underflow), 0);
        check("t6_rst_ready", 32'(in_ready), 0);
        check("t6_rst_busy", 32'(busy), 0);
        tick();
        check("t6_rst_no_clear", 32'(I_clear), 0);
        reset = 1'b1;
        #1;
        check("t6_rel_ready", 32'(in_ready), 1);
        tick();
        check("t6_rel_busy", 32'(busy), 0);
        check("t6_rel_clear", 32'(I_clear), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
